y86_dmem_unit: RTL and testbench

//  Parametrised data-memory stage for the Y86-64 processor. Successor to the combinational memory stage.

---
 rtl/y86_dmem_unit_pkg.sv | 39 +++
 rtl/y86_dmem_unit_array.sv | 41 ++++
 rtl/y86_dmem_unit.sv | 172 +++++++++++++++++
 tb/tb_y86_dmem_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_dmem_unit_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 data-memory stage:
//   - icode values of the instructions that touch data memory
//   - handshake FSM state type
//   - small decode helpers used by the top level
// ---------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Instructions that store a word into data memory.
    function automatic logic isWriteOp(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
    endfunction

    // Instructions that load a word from data memory.
    function automatic logic isReadOp(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
    endfunction

    // ret and popq take their address from the stack pointer in valA;
    // every other memory op uses the ALU result in valE.
    function automatic logic usesValAAddr(input logic [3:0] icode);
        return (icode == I_RET) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/y86_dmem_unit_array.sv
// ---------------------------------------------------------------------------
// y86_dmem_array
// Word-addressed data memory, DATA_W x 2**ADDR_W.
// Synchronous write, asynchronous read, plus an independent asynchronous
// read port used for debug/inspection. The array is never cleared.
// Ports:
//   i_clk      rising-edge clock for writes
//   i_we       write enable
//   i_addr     shared read/write word address
//   i_wdata    write data
//   o_rdata    combinational mem[i_addr]
//   i_dbgAddr  debug read address
//   o_dbgData  combinational mem[i_dbgAddr]
// ---------------------------------------------------------------------------
module y86_dmem_array #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    input  logic [ADDR_W-1:0] i_dbgAddr,
    output logic [DATA_W-1:0] o_dbgData
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata   = r_mem[i_addr];
    assign o_dbgData = r_mem[i_dbgAddr];

endmodule

// File: rtl/y86_dmem_unit.sv
// ---------------------------------------------------------------------------
// y86_dmem_unit
// Data-memory stage for the Y86-64 cores. Accepts one request per
// valid_in && ready handshake, waits LATENCY cycles for memory ops, then
// pulses valid_out for one cycle with valM and dmem_error.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_in / ready    request handshake
//   icode,valA,valE,valP request fields, captured at accept
//   valid_out           one-cycle completion pulse
//   valM                read data (0 for non-reads and errored requests)
//   dmem_error          address out of range, qualified by valid_out
//   dbg_addr / dbg_data combinational debug read port
// ---------------------------------------------------------------------------
module y86_dmem_unit
    import y86_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    output logic              ready,
    output logic              valid_out,
    output logic [DATA_W-1:0] valM,
    output logic              dmem_error,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // LATENCY is at most 8, so the counter only ever holds 0..7.
    localparam int               CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_t       r_state;
    dmem_state_t       w_nextState;
    logic [CNT_W-1:0]  r_waitCnt;

    logic              r_opWrite;
    logic              r_opRead;
    logic              r_opErr;
    logic [ADDR_W-1:0] r_opAddr;
    logic [DATA_W-1:0] r_opData;
    logic [DATA_W-1:0] r_valM;
    logic              r_dmemError;

    logic              w_isWrite;
    logic              w_isRead;
    logic              w_isMem;
    logic [DATA_W-1:0] w_reqAddr;
    logic [DATA_W-1:0] w_reqData;
    logic              w_reqErr;
    logic              w_ready;
    logic              w_validOut;
    logic              w_accept;
    logic              w_commit;
    logic              w_memWe;
    logic [DATA_W-1:0] w_rdData;

    assign w_isWrite = isWriteOp(icode);
    assign w_isRead  = isReadOp(icode);
    assign w_isMem   = w_isWrite || w_isRead;
    assign w_reqAddr = usesValAAddr(icode) ? valA : valE;
    assign w_reqData = (icode == I_CALL) ? valP : valA;
    // Any set bit above the word index is out of range; this also catches
    // negative (two's complement) addresses.
    assign w_reqErr  = |w_reqAddr[DATA_W-1:ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_validOut  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (valid_in) begin
                    w_nextState = w_isMem ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (r_waitCnt == '0) begin
                    w_commit    = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_ready    = 1'b1;
                w_validOut = 1'b1;
                if (valid_in) begin
                    w_nextState = w_isMem ? WAIT : DONE;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        w_accept = valid_in && w_ready;
    end

    // Request capture, wait counter and result registers. Accept and commit
    // are mutually exclusive because ready is low throughout WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt   <= '0;
            r_opWrite   <= 1'b0;
            r_opRead    <= 1'b0;
            r_opErr     <= 1'b0;
            r_opAddr    <= '0;
            r_opData    <= '0;
            r_valM      <= '0;
            r_dmemError <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opWrite <= w_isWrite;
                r_opRead  <= w_isRead;
                r_opErr   <= w_reqErr && w_isMem;
                r_opAddr  <= w_reqAddr[ADDR_W-1:0];
                r_opData  <= w_reqData;
                r_waitCnt <= CNT_LOAD;
                // Non-memory ops complete on the next edge with a clean result.
                if (!w_isMem) begin
                    r_valM      <= '0;
                    r_dmemError <= 1'b0;
                end
            end else if ((r_state == WAIT) && (r_waitCnt != '0)) begin
                r_waitCnt <= r_waitCnt - 1'b1;
            end
            if (w_commit) begin
                r_valM      <= (r_opRead && !r_opErr) ? w_rdData : '0;
                r_dmemError <= r_opErr;
            end
        end
    end

    assign w_memWe = w_commit && r_opWrite && !r_opErr;

    y86_dmem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .i_clk     (clk),
        .i_we      (w_memWe),
        .i_addr    (r_opAddr),
        .i_wdata   (r_opData),
        .o_rdata   (w_rdData),
        .i_dbgAddr (dbg_addr),
        .o_dbgData (dbg_data)
    );

    assign ready      = w_ready;
    assign valid_out  = w_validOut;
    assign valM       = r_valM;
    assign dmem_error = r_dmemError;

endmodule

// File: tb/tb_y86_dmem_unit.sv
// ---------------------------------------------------------------------------
// tb_y86_dmem_unit
// Bench for y86_dmem_unit. Two instances share clock and reset: index 0
// runs with LATENCY=1, index 1 with LATENCY=4. A word-array reference model
// per instance predicts valM, dmem_error and completion latency directly
// from the instruction semantics.
// ---------------------------------------------------------------------------
module tb_y86_dmem_unit;
    import y86_pkg::*;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  vIn;
    logic [3:0]  ic   [2];
    logic [63:0] a    [2];
    logic [63:0] e    [2];
    logic [63:0] p    [2];
    logic [9:0]  dbgA [2];
    logic [1:0]  rdy;
    logic [1:0]  vOut;
    logic [1:0]  err;
    logic [63:0] vM   [2];
    logic [63:0] dbgD [2];

    logic [63:0] mdl [2][1024];

    int total = 0;
    int bad   = 0;

    y86_dmem_unit #(.DATA_W(64), .ADDR_W(10), .LATENCY(LAT0)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(vIn[0]), .icode(ic[0]),
        .valA(a[0]), .valE(e[0]), .valP(p[0]), .ready(rdy[0]),
        .valid_out(vOut[0]), .valM(vM[0]), .dmem_error(err[0]),
        .dbg_addr(dbgA[0]), .dbg_data(dbgD[0])
    );

    y86_dmem_unit #(.DATA_W(64), .ADDR_W(10), .LATENCY(LAT1)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid_in(vIn[1]), .icode(ic[1]),
        .valA(a[1]), .valE(e[1]), .valP(p[1]), .ready(rdy[1]),
        .valid_out(vOut[1]), .valM(vM[1]), .dmem_error(err[1]),
        .dbg_addr(dbgA[1]), .dbg_data(dbgD[1])
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int latOf(input int s);
        return (s == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int poolAddr(input int k);
        return 100 + k * 37;
    endfunction

    // Reference behaviour of one request: which address, what happens to
    // memory, what valM/error come back and after how many edges.
    function automatic void refOp(input int s, input logic [3:0] icd,
                                  input logic [63:0] va, input logic [63:0] ve,
                                  input logic [63:0] vp,
                                  output logic [63:0] expM, output logic expE,
                                  output int expLat);
        logic        isW;
        logic        isR;
        logic [63:0] addr;
        logic [63:0] data;
        isW  = (icd == 4'h4) || (icd == 4'h8) || (icd == 4'hA);
        isR  = (icd == 4'h5) || (icd == 4'h9) || (icd == 4'hB);
        addr = ((icd == 4'h9) || (icd == 4'hB)) ? va : ve;
        data = (icd == 4'h8) ? vp : va;
        expM = 64'd0;
        expE = 1'b0;
        if (!isW && !isR) begin
            expLat = 1;
        end else begin
            expLat = latOf(s) + 1;
            if (addr >= 64'd1024) begin
                expE = 1'b1;
            end else if (isR) begin
                expM = mdl[s][int'(addr)];
            end else begin
                mdl[s][int'(addr)] = data;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkMem(input int s, input int addr, input string tag);
        dbgA[s] = 10'(addr);
        #1;
        checkOutput(tag, dbgD[s], mdl[s][addr]);
    endtask

    // One idle cycle after a completion: the pulse must be gone.
    task automatic checkIdleAfter(input int s, input string tag);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 64'(vOut[s]), 64'd0);
        checkOutput({tag, "_rdy"}, 64'(rdy[s]), 64'd1);
    endtask

    // Present one request, wait for its completion and compare the result.
    // Returns at the negedge where valid_out is seen, so an immediate second
    // call exercises a back-to-back accept in DONE. With toggle set, valid_in
    // and the request fields are scrambled while the unit is busy.
    task automatic applyStimulus(input int s, input logic [3:0] icd,
                                 input logic [63:0] va, input logic [63:0] ve,
                                 input logic [63:0] vp, input bit toggle,
                                 input string tag);
        logic [63:0] expM;
        logic        expE;
        int          expLat;
        int          guard;
        int          edges;
        int          nrdy;
        guard = 0;
        while (!rdy[s] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy[s]) begin
            checkOutput({tag, "_ready_timeout"}, 64'(rdy[s]), 64'd1);
            return;
        end
        ic[s]  = icd;
        a[s]   = va;
        e[s]   = ve;
        p[s]   = vp;
        vIn[s] = 1'b1;
        refOp(s, icd, va, ve, vp, expM, expE, expLat);
        @(posedge clk);
        @(negedge clk);
        vIn[s] = 1'b0;
        edges  = 1;
        nrdy   = 0;
        while (!vOut[s] && edges < 40) begin
            if (!rdy[s]) nrdy++;
            if (toggle) begin
                vIn[s] = ~vIn[s];
                ic[s]  = I_RMMOVQ;
                a[s]   = 64'hBADBAD;
                e[s]   = 64'd900;
            end
            @(negedge clk);
            edges++;
        end
        vIn[s] = 1'b0;
        checkOutput({tag, "_latency"}, 64'(edges), 64'(expLat));
        checkOutput({tag, "_busy"}, 64'(nrdy), 64'(expLat - 1));
        checkOutput({tag, "_valM"}, vM[s], expM);
        checkOutput({tag, "_err"}, 64'(err[s]), 64'(expE));
    endtask

    // Directed steps followed by a randomized phase, all in one sequence.
    initial begin
        logic [3:0]  icList [13];
        logic [3:0]  icd;
        logic [63:0] addr;
        logic [63:0] ra;
        logic [63:0] re;
        int          r;

        icList = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'h0,
                   4'h1, 4'h2, 4'h3, 4'h7, 4'hC};

        rst_n = 1'b0;
        vIn   = 2'b00;
        for (int s = 0; s < 2; s++) begin
            ic[s]   = 4'h0;
            a[s]    = 64'd0;
            e[s]    = 64'd0;
            p[s]    = 64'd0;
            dbgA[s] = 10'd0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("reset%0d_ready", s), 64'(rdy[s]), 64'd1);
            checkOutput($sformatf("reset%0d_vout", s), 64'(vOut[s]), 64'd0);
            checkOutput($sformatf("reset%0d_valM", s), vM[s], 64'd0);
            checkOutput($sformatf("reset%0d_err", s), 64'(err[s]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Populate a known pool of addresses plus the special locations.
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 16; k++) begin
                applyStimulus(s, I_RMMOVQ, {$urandom, $urandom}, 64'(poolAddr(k)),
                              64'd0, 1'b0, "pre");
            end
            applyStimulus(s, I_RMMOVQ, 64'h1016CAFE, 64'd1016, 64'd0, 1'b0, "pre1016");
            applyStimulus(s, I_RMMOVQ, 64'h900900, 64'd900, 64'd0, 1'b0, "pre900");
        end

        // LATENCY=1 directed checks.
        applyStimulus(0, I_RMMOVQ, 64'd88, 64'd32, 64'd0, 1'b0, "rmmovq32");
        checkIdleAfter(0, "rmmovq32");
        applyStimulus(0, I_MRMOVQ, 64'd0, 64'd32, 64'd0, 1'b0, "mrmovq32");
        checkOutput("mrmovq32_value", vM[0], 64'd88);
        applyStimulus(0, I_CALL, 64'd0, 64'd24, 64'h100, 1'b0, "call24");
        applyStimulus(0, I_RET, 64'd24, 64'd0, 64'd0, 1'b0, "ret24");
        checkOutput("ret24_value", vM[0], 64'h100);
        applyStimulus(0, I_PUSHQ, 64'd55, 64'd47, 64'd0, 1'b0, "pushq47");
        applyStimulus(0, I_POPQ, 64'd47, 64'd0, 64'd0, 1'b0, "popq47");
        checkOutput("popq47_value", vM[0], 64'd55);
        applyStimulus(0, I_MRMOVQ, 64'd0, 64'd1024, 64'd0, 1'b0, "rd1024");
        checkOutput("rd1024_flag", 64'(err[0]), 64'd1);
        applyStimulus(0, I_RMMOVQ, 64'h5555, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0, "wrneg8");
        checkMem(0, 1016, "wrneg8_mem1016");
        applyStimulus(0, 4'h6, 64'h1234, 64'd32, 64'h77, 1'b0, "opq");
        checkMem(0, 32, "opq_mem32");
        applyStimulus(0, I_RMMOVQ, 64'hFEED_F00D, 64'd1023, 64'd0, 1'b0, "wr1023");
        applyStimulus(0, I_MRMOVQ, 64'd0, 64'd1023, 64'd0, 1'b0, "rd1023");
        checkOutput("rd1023_value", vM[0], 64'hFEED_F00D);
        checkIdleAfter(0, "rd1023");

        // LATENCY=4: busy window, ignored inputs while busy, back-to-back.
        applyStimulus(1, I_RMMOVQ, 64'h44, 64'd60, 64'd0, 1'b0, "l4_wr60");
        checkIdleAfter(1, "l4_wr60");
        applyStimulus(1, I_MRMOVQ, 64'd0, 64'd60, 64'd0, 1'b1, "l4_rd60_toggle");
        checkOutput("l4_rd60_value", vM[1], 64'h44);
        checkMem(1, 900, "l4_toggle_mem900");
        applyStimulus(1, I_RMMOVQ, 64'h99, 64'd61, 64'd0, 1'b0, "l4_b2b_wr");
        applyStimulus(1, I_MRMOVQ, 64'd0, 64'd61, 64'd0, 1'b0, "l4_b2b_rd");
        applyStimulus(1, 4'h6, 64'd0, 64'd0, 64'd0, 1'b0, "l4_b2b_opq");
        checkIdleAfter(1, "l4_b2b");

        // Reset while a LATENCY=4 write is waiting: nothing may commit.
        ic[1]  = I_RMMOVQ;
        a[1]   = 64'hABCD_ABCD;
        e[1]   = 64'(poolAddr(5));
        vIn[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vIn[1] = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 64'(rdy[1]), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 64'(rdy[1]), 64'd1);
        checkOutput("abort_vout", 64'(vOut[1]), 64'd0);
        checkOutput("abort_valM", vM[1], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkMem(1, poolAddr(5), "abort_mem");
        @(negedge clk);

        // Randomized traffic against the reference model.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 30; n++) begin
                icd = icList[$urandom_range(0, 12)];
                r   = int'($urandom_range(0, 9));
                if (r == 0) begin
                    addr = 64'd1024 + 64'($urandom);
                end else if (r == 1) begin
                    addr = 64'd0 - 64'($urandom_range(1, 64));
                end else begin
                    addr = 64'(poolAddr(int'($urandom_range(0, 15))));
                end
                ra = {$urandom, $urandom};
                re = {$urandom, $urandom};
                if ((icd == I_RET) || (icd == I_POPQ)) begin
                    ra = addr;
                end else begin
                    re = addr;
                end
                applyStimulus(s, icd, ra, re, {$urandom, $urandom}, 1'b0,
                              $sformatf("rand%0d_%0d", s, n));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            for (int k = 0; k < 16; k++) begin
                checkMem(s, poolAddr(k), $sformatf("final%0d_pool%0d", s, k));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
